// File: rtl/random_playout_engine.sv
// random_playout_engine
// Single-trial 2048 playout engine. Loads a 16-cell board, repeatedly draws a
// random direction from an external xorshift word, slides/merges the board,
// spawns a tile after every changing move and stops once no move is possible.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   start              one-cycle pulse, (re)starts a trial from initial_board
//   initial_board[80]  16 cells x 5-bit exponent, cell i at [5i+4:5i], i=4*row+col
//   random[23]         current xorshift word, advances after each random_clk strobe
//   restrected[2]      direction subject to probabilistic rejection
//   restrect_prob[3]   rejection probability in eighths
//   random_clk         one-cycle request strobe for the next random word
//   calc_done          one-cycle pulse per completed move attempt (combinational)
//   stuck              level, trial has ended
//   succ_count[15]     successful moves in the current trial (saturating)
//   board[80]          current board
//   max_tile[5]        largest exponent on board (only with PLAYOUT_MAX_TILE_EN)
//
// Optional feature macro: PLAYOUT_MAX_TILE_EN
module random_playout_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] initial_board,
  input  logic [22:0] random,
  input  logic [1:0]  restrected,
  input  logic [2:0]  restrect_prob,
  output logic        random_clk,
  output logic        calc_done,
  output logic        stuck,
  output logic [14:0] succ_count,
  output logic [79:0] board
`ifdef PLAYOUT_MAX_TILE_EN
  ,
  output logic [4:0]  max_tile
`endif
);

  localparam int unsigned CELL_W  = 5;
  localparam int unsigned BOARD_W = 16 * CELL_W;
  localparam int unsigned CNT_W   = 15;

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] CHECK = 4'd1;
  localparam logic [3:0] DRAW  = 4'd2;
  localparam logic [3:0] DWAIT = 4'd3;
  localparam logic [3:0] MOVE  = 4'd4;
  localparam logic [3:0] SPAWN = 4'd5;
  localparam logic [3:0] SWAIT = 4'd6;
  localparam logic [3:0] PLACE = 4'd7;
  localparam logic [3:0] STUCK = 4'd8;

  logic [3:0]         state, next_state;
  logic [BOARD_W-1:0] board_d, slid, placed;
  logic [CNT_W-1:0]   succ_d;
  logic               rclk_d, stuck_d;
  logic               reject, no_moves;
  logic               unused_random;

  // Bit offset of cell idx inside a board vector.
  function automatic logic [6:0] cell_base(input logic [3:0] idx);
    return 7'(idx) * 7'd5;
  endfunction

  // Cell index of position k (k=0 nearest the wall) on line l for direction dir.
  function automatic logic [3:0] line_cell(input logic [1:0] dir,
                                           input logic [1:0] l,
                                           input logic [1:0] k);
    logic [3:0] r;
    case (dir)
      2'd0:    r = {k, l};               // up: column l, top first
      2'd1:    r = {l, 2'd3 - k};        // right: row l, rightmost first
      2'd2:    r = {2'd3 - k, l};        // down: column l, bottom first
      default: r = {l, k};               // left: row l, leftmost first
    endcase
    return r;
  endfunction

  // Slide one line toward index 0; each pair merges at most once.
  function automatic logic [3:0][4:0] slide_line(input logic [3:0][4:0] ln);
    logic [4:0][4:0] t;
    logic [3:0][4:0] o;
    logic [2:0]      k;
    logic [1:0]      n;
    logic            skip;
    t    = '0;
    o    = '0;
    k    = 3'd0;
    n    = 2'd0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ln[2'(i)] != 5'd0) begin
        t[k] = ln[2'(i)];
        k    = k + 3'd1;
      end
    end
    // t[4] stays zero, so a nonzero tile never pairs with the padding slot
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (t[3'(i)] != 5'd0) begin
        if (t[3'(i)] == t[3'(i + 1)]) begin
          o[n] = (t[3'(i)] == 5'd31) ? 5'd31 : t[3'(i)] + 5'd1;
          skip = 1'b1;
        end else begin
          o[n] = t[3'(i)];
        end
        n = n + 2'd1;
      end
    end
    return o;
  endfunction

  function automatic logic [79:0] slide_board(input logic [79:0] b,
                                              input logic [1:0]  dir);
    logic [79:0]     r;
    logic [3:0][4:0] ln, sl;
    r = b;
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 4; k++)
        ln[2'(k)] = b[cell_base(line_cell(dir, 2'(l), 2'(k))) +: 5];
      sl = slide_line(ln);
      for (int k = 0; k < 4; k++)
        r[cell_base(line_cell(dir, 2'(l), 2'(k))) +: 5] = sl[2'(k)];
    end
    return r;
  endfunction

  // True when there is no empty cell and no adjacent equal pair.
  function automatic logic board_stuck(input logic [79:0] b);
    logic mv;
    mv = 1'b0;
    for (int i = 0; i < 16; i++)
      if (b[cell_base(4'(i)) +: 5] == 5'd0) mv = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (b[cell_base(4'(4 * r + c)) +: 5] == b[cell_base(4'(4 * r + c + 1)) +: 5])
          mv = 1'b1;
    for (int i = 0; i < 12; i++)
      if (b[cell_base(4'(i)) +: 5] == b[cell_base(4'(i + 4)) +: 5]) mv = 1'b1;
    return !mv;
  endfunction

  // Put tile v into the first empty cell scanning p, p+1, ... mod 16.
  function automatic logic [79:0] place_tile(input logic [79:0] b,
                                             input logic [3:0]  p,
                                             input logic [4:0]  v);
    logic [79:0] r;
    logic        done;
    logic [3:0]  idx;
    r    = b;
    done = 1'b0;
    for (int j = 0; j < 16; j++) begin
      idx = p + 4'(j);
      if (!done && r[cell_base(idx) +: 5] == 5'd0) begin
        r[cell_base(idx) +: 5] = v;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  assign slid     = slide_board(board, random[1:0]);
  assign placed   = place_tile(board, random[8:5],
                               (random[12:9] == 4'd0) ? 5'd2 : 5'd1);
  assign reject   = (random[1:0] == restrected) && (random[4:2] < restrect_prob);
  assign no_moves = board_stuck(board);
  assign unused_random = ^random[22:13];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, datapath next values and the calc_done strobe.
  always_comb begin
    next_state = state;
    board_d    = board;
    succ_d     = succ_count;
    rclk_d     = 1'b0;
    stuck_d    = 1'b0;
    calc_done  = 1'b0;
    if (start) begin
      board_d    = initial_board;
      succ_d     = '0;
      next_state = CHECK;
    end else begin
      case (state)
        IDLE: next_state = IDLE;
        CHECK: begin
          if (no_moves) begin
            next_state = STUCK;
            stuck_d    = 1'b1;
          end else begin
            next_state = DRAW;
            rclk_d     = 1'b1;
          end
        end
        DRAW:  next_state = DWAIT;
        DWAIT: next_state = MOVE;
        MOVE: begin
          if (reject || slid == board) begin
            calc_done  = 1'b1;
            next_state = DRAW;
            rclk_d     = 1'b1;
          end else begin
            board_d    = slid;
            succ_d     = (succ_count == 15'h7FFF) ? succ_count : succ_count + 15'd1;
            next_state = SPAWN;
            rclk_d     = 1'b1;
          end
        end
        SPAWN: next_state = SWAIT;
        SWAIT: next_state = PLACE;
        PLACE: begin
          board_d    = placed;
          calc_done  = 1'b1;
          next_state = CHECK;
        end
        STUCK: begin
          next_state = STUCK;
          stuck_d    = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Registered outputs; random_clk and stuck track the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board      <= '0;
      succ_count <= '0;
      random_clk <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      board      <= board_d;
      succ_count <= succ_d;
      random_clk <= rclk_d;
      stuck      <= stuck_d;
    end
  end

`ifdef PLAYOUT_MAX_TILE_EN
  function automatic logic [4:0] board_max(input logic [79:0] b);
    logic [4:0] m;
    m = 5'd0;
    for (int i = 0; i < 16; i++)
      if (b[cell_base(4'(i)) +: 5] > m) m = b[cell_base(4'(i)) +: 5];
    return m;
  endfunction

  // Follows board one cycle later; a start loads it straight from initial_board.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        max_tile <= 5'd0;
    else if (start) max_tile <= board_max(initial_board);
    else            max_tile <= board_max(board);
  end
`endif

endmodule

// File: tb/tb_random_playout_engine.sv
// tb_random_playout_engine
// Directed bench for random_playout_engine: reset, stuck load, each slide
// direction, spawn placement, rejection, no-op attempts, saturation, restart
// and mid-trial reset. Define PLAYOUT_MAX_TILE_EN to also cover max_tile.
module tb_random_playout_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] initial_board;
  logic [22:0] random;
  logic [1:0]  restrected;
  logic [2:0]  restrect_prob;
  logic        random_clk;
  logic        calc_done;
  logic        stuck;
  logic [14:0] succ_count;
  logic [79:0] board;
`ifdef PLAYOUT_MAX_TILE_EN
  logic [4:0]  max_tile;
`endif

  int checks   = 0;
  int failures = 0;
  int rclk_cnt = 0;
  int cd_cnt   = 0;
  int rclk_back = 0;
  logic rclk_prev = 1'b0;
  int c0, r0;
  logic [79:0] cb;

  always #5 clk = ~clk;

  random_playout_engine dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .initial_board (initial_board),
    .random        (random),
    .restrected    (restrected),
    .restrect_prob (restrect_prob),
    .random_clk    (random_clk),
    .calc_done     (calc_done),
    .stuck         (stuck),
    .succ_count    (succ_count),
    .board         (board)
`ifdef PLAYOUT_MAX_TILE_EN
    ,
    .max_tile      (max_tile)
`endif
  );

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (random_clk) rclk_cnt++;
    if (calc_done) cd_cnt++;
    if (random_clk && rclk_prev) rclk_back++;
    rclk_prev = random_clk;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one cycle after the start pulse (state CHECK).
  task automatic pulse_start(input logic [79:0] b);
    initial_board = b;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    initial_board = '0;
    random        = 23'h7FFFFF;
    restrected    = 2'd0;
    restrect_prob = 3'd0;

    // Reset
    tick(3);
    chk("rst_board", board, 80'd0);
    chk("rst_succ", 80'(succ_count), 80'd0);
    chk("rst_stuck", 80'(stuck), 80'd0);
    chk("rst_rclk", 80'(random_clk), 80'd0);
    chk("rst_cd", 80'(calc_done), 80'd0);
`ifdef PLAYOUT_MAX_TILE_EN
    chk("rst_max", 80'(max_tile), 80'd0);
`endif
    rst = 1'b0;
    c0 = cd_cnt; r0 = rclk_cnt;
    tick(20);
    chk("idle_rclk_pulses", 80'(rclk_cnt - r0), 80'd0);
    chk("idle_cd_pulses", 80'(cd_cnt - c0), 80'd0);

    // Stuck load: checkerboard of 1/2
    cb = '0;
    for (int i = 0; i < 16; i++)
      cb[5*i +: 5] = (((i / 4) + (i % 4)) % 2 != 0) ? 5'd2 : 5'd1;
    pulse_start(cb);
    r0 = rclk_cnt;
    chk("stk_load_board", board, cb);
    chk("stk_t1_stuck", 80'(stuck), 80'd0);
`ifdef PLAYOUT_MAX_TILE_EN
    chk("stk_max", 80'(max_tile), 80'd2);
`endif
    tick(1);
    chk("stk_t2_stuck", 80'(stuck), 80'd1);
    chk("stk_succ", 80'(succ_count), 80'd0);
    tick(10);
    chk("stk_rclk_pulses", 80'(rclk_cnt - r0), 80'd0);
    chk("stk_hold", 80'(stuck), 80'd1);
    chk("stk_board_frozen", board, cb);

    // Move left: row0=[1,1,0,0], spawn exponent 1 at cell1
    random = 23'h000203; restrected = 2'd0; restrect_prob = 3'd0;
    pulse_start(80'h21);
    c0 = cd_cnt; r0 = rclk_cnt;
    chk("left_t1_board", board, 80'h21);
    chk("left_t1_stuck", 80'(stuck), 80'd0);
    tick(1);
    chk("left_draw_rclk", 80'(random_clk), 80'd1);
    tick(2);
    chk("left_move_cd", 80'(calc_done), 80'd0);
    chk("left_move_board", board, 80'h21);
    tick(1);
    chk("left_slid", board, 80'h02);
    chk("left_succ", 80'(succ_count), 80'd1);
    chk("left_spawn_rclk", 80'(random_clk), 80'd1);
    tick(2);
    chk("left_place_cd", 80'(calc_done), 80'd1);
    tick(1);
    chk("left_placed", board, 80'h22);
    chk("left_cd_pulses", 80'(cd_cnt - c0), 80'd1);
    chk("left_rclk_pulses", 80'(rclk_cnt - r0), 80'd2);
    tick(3);
    chk("noop_cd", 80'(calc_done), 80'd1);
    chk("noop_board", board, 80'h22);
    chk("noop_succ", 80'(succ_count), 80'd1);

    // Restricted direction with random[4:2]=7, prob 7: not rejected, spawn exponent 2
    random = 23'h00001F; restrected = 2'd3; restrect_prob = 3'd7;
    pulse_start(80'h21);
    tick(7);
    chk("edge_prob_board", board, 80'h42);
    chk("edge_prob_succ", 80'(succ_count), 80'd1);

    // Rejection: every attempt rejected
    random = 23'h000003; restrected = 2'd3; restrect_prob = 3'd7;
    pulse_start(80'h21);
    c0 = cd_cnt; r0 = rclk_cnt;
    tick(30);
    chk("rej_cd_pulses", 80'(cd_cnt - c0), 80'd9);
    chk("rej_rclk_pulses", 80'(rclk_cnt - r0), 80'd10);
    chk("rej_board", board, 80'h21);
    chk("rej_succ", 80'(succ_count), 80'd0);

    // Start during MOVE suppresses calc_done
    pulse_start(80'h21);
    tick(3);
    start = 1'b1;
    #1;
    chk("start_in_move_cd", 80'(calc_done), 80'd0);
    tick(1);
    start = 1'b0;
    chk("start_in_move_board", board, 80'h21);

    // Right: row0=[1,1,2,0] -> [0,0,2,2]
    random = 23'h000201; restrected = 2'd0; restrect_prob = 3'd0;
    pulse_start(80'h821);
    tick(4);
    chk("right_slid", board, 80'h10800);
    tick(3);
    chk("right_placed", board, 80'h10801);

    // Down: column 0 = [1,1,1,0] top to bottom
    random = 23'h000202;
    pulse_start((80'd1) | (80'd1 << 20) | (80'd1 << 40));
    tick(4);
    chk("down_slid", board, (80'd2 << 60) | (80'd1 << 40));
    tick(3);
    chk("down_placed", board, (80'd2 << 60) | (80'd1 << 40) | 80'd1);

    // Up: column 1 = [1,1,1,1]
    random = 23'h000200;
    pulse_start((80'd1 << 5) | (80'd1 << 25) | (80'd1 << 45) | (80'd1 << 65));
    tick(4);
    chk("up_slid", board, (80'd2 << 5) | (80'd2 << 25));
    tick(3);
    chk("up_placed", board, (80'd2 << 5) | (80'd2 << 25) | 80'd1);

    // Saturation: [31,31,0,0] left keeps 31
    random = 23'h000203;
    pulse_start(80'h3FF);
`ifdef PLAYOUT_MAX_TILE_EN
    chk("sat_max_t1", 80'(max_tile), 80'd31);
`endif
    tick(4);
    chk("sat_slid", board, 80'h1F);
    tick(3);
    chk("sat_placed", board, 80'h3F);
`ifdef PLAYOUT_MAX_TILE_EN
    chk("sat_max", 80'(max_tile), 80'd31);
`endif

    // Restart during SWAIT
    pulse_start(80'h21);
    tick(5);
    c0 = cd_cnt;
    initial_board = 80'h60;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("restart_board", board, 80'h60);
    chk("restart_succ", 80'(succ_count), 80'd0);
    chk("restart_cd", 80'(calc_done), 80'd0);
    chk("restart_cd_pulses", 80'(cd_cnt - c0), 80'd0);

    // Asynchronous reset mid-trial
    tick(3);
    rst = 1'b1;
    #1;
    chk("arst_board", board, 80'd0);
    chk("arst_succ", 80'(succ_count), 80'd0);
    chk("arst_stuck", 80'(stuck), 80'd0);
    chk("arst_rclk", 80'(random_clk), 80'd0);
    tick(2);
    rst = 1'b0;
    r0 = rclk_cnt;
    tick(20);
    chk("arst_idle_rclk", 80'(rclk_cnt - r0), 80'd0);

    chk("rclk_back_to_back", 80'(rclk_back), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
